reg_file_rd: RTL and testbench
==============================

# reg_file_rd

Register file for the single-cycle datapath. It accepts the destination-register write selected by the writeback mux, and serves the two source-operand reads for the next instruction. The write port takes one write per cycle. The read side is a registered two-port read with a one-cycle request/valid handshake. Register 0 is hardwired to zero, and same-cycle read-after-write forwarding is a compile-time option.

## Interface
Parameters:
- bit_size, 32, data width of each register and of the read/write data ports
- addr_size, 5, register address width; depth is 2**addr_size (32 registers)

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  reset, asynchronous, active-low; clears all state while low
- wen  input  1  write enable for the destination register
- wa  input  addr_size  destination register address
- wd  input  bit_size  write data, taken from the writeback mux output
- ren  input  1  read request; captures ra1/ra2 for this cycle
- ra1  input  addr_size  source register 1 address
- ra2  input  addr_size  source register 2 address
- rd1  output  bit_size  registered read data for ra1
- rd2  output  bit_size  registered read data for ra2
- rvalid  output  1  high for exactly one cycle when rd1/rd2 hold data for the request made on the previous edge

## Operation
- Storage: 2**addr_size registers of bit_size bits.
- Write: on a rising edge with wen=1 and wa!=0, register[wa] takes wd.
  - A write with wa=0 is discarded; register 0 always reads as 0.
- Read: on a rising edge with ren=1:
  - rd1 takes register[ra1] and rd2 takes register[ra2].
  - rvalid is set to 1.
- With ren=0, rvalid clears to 0 on the next edge, and rd1/rd2 hold their last value.
- Back-to-back requests (ren=1 on consecutive edges) are always accepted. There is no stall and no backpressure.
- ra1==ra2 is legal; both outputs return the same value.
- Same-edge read and write to the same nonzero address: behaviour is set by the Configuration section.
- A same-edge write with wa=0 never affects the read of address 0.

## Timing
- Read latency is 1 cycle. A request sampled at edge N gives rd1/rd2/rvalid valid after edge N, for the cycle N..N+1.
- Write latency is 1 cycle. Data written at edge N is visible to a read request sampled at edge N+1 or later, in either configuration.
- Reset, while rst=0:
  - All registers are 0.
  - rd1=0, rd2=0, rvalid=0.
  - Writes and reads are ignored.
- Reset asserted mid-operation:
  - Outputs and storage clear immediately, asynchronously.
  - A request sampled on the edge where reset is asserted does not produce rvalid.
- Reset release: the first edge with rst=1 may carry a read or a write and is processed normally.
- No multi-cycle state machine. Sequential state is the storage array, the rd1/rd2 registers, and the rvalid flag.

## Configuration
- Macro: REGFILE_BYPASS_EN. It controls a same-edge read (ren=1) and write (wen=1) where wa==ra1 or wa==ra2, wa!=0.
- Defined (write-first forwarding): the matching rd1/rd2 captures wd. The storage write also occurs.
- Not defined (read-first): the matching rd1/rd2 captures the old register contents. The new value is visible from the next read onward.

## Test plan
- Reset check: rst=0 with random wen/ren activity -> rd1=0, rd2=0, rvalid=0. After release, reading ra1=5, ra2=31 -> rd1=0, rd2=0, rvalid=1 for one cycle.
- Basic write/read: write 0xDEADBEEF to r7 at edge N, request ra1=7, ra2=0 at edge N+1 -> rd1=0xDEADBEEF, rd2=0, rvalid=1.
- Register 0 protection: write 0x12345678 to r0, then read ra1=0 -> rd1=0.
- Same-edge collision: r3 holds 0x1. At one edge write 0xAAAA5555 to r3 and request ra1=3, ra2=3 -> rd1=rd2=0xAAAA5555 with REGFILE_BYPASS_EN, 0x1 without. A following read gives 0xAAAA5555 in both builds.
- Streaming reads: fill r1..r4 with 1..4, then hold ren=1 for 4 edges with ra1=1..4 -> rvalid held high 4 cycles, rd1 sequence 1,2,3,4. rvalid drops one cycle after ren falls.
- Mid-operation reset: r9=0xCAFEF00D. Drop rst asynchronously while ren=1 -> rd1 and rvalid clear immediately. After release, a read of r9 returns 0.

Source files
------------

// File: rtl/reg_file_rd.sv
// rtl/reg_file_rd.sv - register file, registered two-port read, r0 hardwired to zero; REGFILE_BYPASS_EN selects write-first forwarding
module reg_file_rd #(
    parameter int bit_size  = 32,
    parameter int addr_size = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wen,
    input  logic [addr_size-1:0] wa,
    input  logic [bit_size-1:0]  wd,
    input  logic                 ren,
    input  logic [addr_size-1:0] ra1,
    input  logic [addr_size-1:0] ra2,
    output logic [bit_size-1:0]  rd1,
    output logic [bit_size-1:0]  rd2,
    output logic                 rvalid
);

    localparam int depth = 2 ** addr_size;

    logic [bit_size-1:0] regs [depth];
    logic                wr_ok;
    logic [bit_size-1:0] rd1_next;
    logic [bit_size-1:0] rd2_next;

    // Writes to r0 are dropped here, so r0 stays at its reset value of zero.
    assign wr_ok = wen && (wa != '0);

    always_comb begin
        rd1_next = regs[ra1];
        rd2_next = regs[ra2];
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (wa == ra1)) rd1_next = wd;
        if (wr_ok && (wa == ra2)) rd2_next = wd;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < depth; i++) regs[i] <= '0;
            rd1    <= '0;
            rd2    <= '0;
            rvalid <= 1'b0;
        end else begin
            if (wr_ok) regs[wa] <= wd;
            rvalid <= ren;
            if (ren) begin
                rd1 <= rd1_next;
                rd2 <= rd2_next;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_rd.sv
// tb/tb_reg_file_rd.sv - randomized and directed bench for reg_file_rd against an array model
module tb_reg_file_rd;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wen = 1'b0;
    logic [4:0]  wa  = '0;
    logic [31:0] wd  = '0;
    logic        ren = 1'b0;
    logic [4:0]  ra1 = '0;
    logic [4:0]  ra2 = '0;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        rvalid;

    reg_file_rd #(.bit_size(32), .addr_size(5)) dut (
        .clk(clk), .rst(rst), .wen(wen), .wa(wa), .wd(wd),
        .ren(ren), .ra1(ra1), .ra2(ra2),
        .rd1(rd1), .rd2(rd2), .rvalid(rvalid)
    );

    always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
    localparam bit bypass = 1'b1;
`else
    localparam bit bypass = 1'b0;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m [32];
    logic [31:0] e1 = '0;
    logic [31:0] e2 = '0;
    logic        ev = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m[i] = '0;
        e1 = '0;
        e2 = '0;
        ev = 1'b0;
    endtask

    // Called at a falling edge: drive, predict, cross the rising edge, compare.
    task automatic step(input string tag, input logic w, input logic [4:0] a, input logic [31:0] d,
                        input logic r, input logic [4:0] a1, input logic [4:0] a2);
        wen = w; wa = a; wd = d; ren = r; ra1 = a1; ra2 = a2;
        if (!rst) begin
            model_reset();
        end else begin
            if (r) begin
                e1 = (bypass && w && a != 0 && a == a1) ? d : m[a1];
                e2 = (bypass && w && a != 0 && a == a2) ? d : m[a2];
            end
            ev = r;
            if (w && a != 0) m[a] = d;
        end
        @(posedge clk);
        #1;
        check({tag, "_rd1"}, rd1, e1);
        check({tag, "_rd2"}, rd2, e2);
        check({tag, "_rvalid"}, 32'(rvalid), 32'(ev));
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        @(negedge clk);

        for (int i = 0; i < 6; i++)
            step("in_reset", 1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom), 5'($urandom));
        rst = 1'b1;
        step("post_reset", 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd31);
        check("post_reset_rvalid_const", 32'(rvalid), 32'd1);
        step("post_reset_idle", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);

        step("basic_wr", 1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0);
        step("basic_rd", 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd0);
        check("basic_rd1_const", rd1, 32'hDEADBEEF);

        step("r0_wr", 1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 5'd0);
        step("r0_rd", 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd7);
        check("r0_rd1_const", rd1, 32'd0);
        step("r0_same_edge", 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0);

        step("coll_init", 1'b1, 5'd3, 32'h1, 1'b0, 5'd0, 5'd0);
        step("coll", 1'b1, 5'd3, 32'hAAAA5555, 1'b1, 5'd3, 5'd3);
        check("coll_rd1_const", rd1, bypass ? 32'hAAAA5555 : 32'h1);
        step("coll_after", 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3);
        check("coll_after_const", rd2, 32'hAAAA5555);

        for (int i = 1; i <= 4; i++)
            step("fill", 1'b1, 5'(i), 32'(i), 1'b0, 5'd0, 5'd0);
        for (int i = 1; i <= 4; i++) begin
            step("stream", 1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 5'(5 - i));
            check("stream_seq", rd1, 32'(i));
        end
        step("stream_drop", 1'b0, 5'd0, 32'd0, 1'b0, 5'd1, 5'd1);
        check("stream_hold_rd1", rd1, 32'd4);

        for (int i = 0; i < 300; i++) begin
            logic narrow;
            narrow = 1'($urandom);
            step("rand", 1'($urandom), narrow ? 5'($urandom_range(0, 3)) : 5'($urandom),
                 $urandom, 1'($urandom_range(0, 3) != 0),
                 narrow ? 5'($urandom_range(0, 3)) : 5'($urandom),
                 narrow ? 5'($urandom_range(0, 3)) : 5'($urandom));
        end

        step("midrst_wr", 1'b1, 5'd9, 32'hCAFEF00D, 1'b0, 5'd0, 5'd0);
        step("midrst_rd", 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9);
        ren = 1'b1; ra1 = 5'd9; ra2 = 5'd9; wen = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("midrst_async_rd1", rd1, 32'd0);
        check("midrst_async_rvalid", 32'(rvalid), 32'd0);
        @(posedge clk);
        #1;
        check("midrst_edge_rvalid", 32'(rvalid), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step("midrst_after", 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9);
        check("midrst_after_const", rd1, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
